// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter placing bytes from two requesters onto one UART transmitter,
// with tx_done rising-edge completion, a completion timeout and an inter-frame gap.
module uart_tx_arbiter #(
    parameter int N              = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 62496
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         start_tx,
    output logic [N-1:0] data_out,
    input  logic         tx_done,
    output logic         busy,
    output logic         err,
    output logic         last_src
);

    localparam int MAX_COUNT = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W     = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_done_prev_q;
    logic             tx_done_rise;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             start_tx_q, start_tx_d;
    logic [N-1:0]     data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             last_src_q, last_src_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        start_tx_d   = 1'b0;
        err_d        = 1'b0;
        data_out_d   = data_out_q;
        last_src_d   = last_src_q;
        tx_done_rise = tx_done && !tx_done_prev_q;

        case (state_q)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (req0 && (!req1 || last_src_q)) begin
                    gnt0_d     = 1'b1;
                    data_out_d = data0;
                    last_src_d = 1'b0;
                    state_d    = START;
                end else if (req1) begin
                    gnt1_d     = 1'b1;
                    data_out_d = data1;
                    last_src_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                start_tx_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (tx_done_rise) begin
                    done0_d = !last_src_q;
                    done1_d = last_src_q;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            tx_done_prev_q <= 1'b0;
            gnt0_q         <= 1'b0;
            gnt1_q         <= 1'b0;
            done0_q        <= 1'b0;
            done1_q        <= 1'b0;
            start_tx_q     <= 1'b0;
            data_out_q     <= '0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            last_src_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tx_done_prev_q <= tx_done;
            gnt0_q         <= gnt0_d;
            gnt1_q         <= gnt1_d;
            done0_q        <= done0_d;
            done1_q        <= done1_d;
            start_tx_q     <= start_tx_d;
            data_out_q     <= data_out_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            last_src_q     <= last_src_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign start_tx = start_tx_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign last_src = last_src_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of arbitration vectors checked through a grant/done
// scoreboard, plus hand sequences for stale tx_done, timeout, async reset and zero gap.
module tb_uart_tx_arbiter;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         req0, req1, tx_done;
    logic [N-1:0] data0, data1;
    logic         gnt0, gnt1, done0, done1, start_tx, busy, err, last_src;
    logic [N-1:0] data_out;

    logic         b_req0, b_req1, b_tx_done;
    logic [N-1:0] b_data0, b_data1;
    logic         b_gnt0, b_gnt1, b_done0, b_done1, b_start_tx, b_busy, b_err, b_last_src;
    logic [N-1:0] b_data_out;

    uart_tx_arbiter #(.N(N), .GAP_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .start_tx(start_tx), .data_out(data_out), .tx_done(tx_done),
        .busy(busy), .err(err), .last_src(last_src)
    );

    uart_tx_arbiter #(.N(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_nogap (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(b_req1), .data0(b_data0), .data1(b_data1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .start_tx(b_start_tx), .data_out(b_data_out), .tx_done(b_tx_done),
        .busy(b_busy), .err(b_err), .last_src(b_last_src)
    );

    typedef struct {
        logic         r0;
        logic         r1;
        logic [N-1:0] d0;
        logic [N-1:0] d1;
        logic         exp_src;
        logic [N-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic         src;
        logic [N-1:0] data;
    } gnt_exp_t;

    int       vec_cnt  = 0;
    int       miss_cnt = 0;
    gnt_exp_t gnt_q[$];
    logic     done_q[$];
    bit       expect_err = 1'b0;
    gnt_exp_t mon_e;
    logic     mon_d;
    vec_t     vecs[6];
    vec_t     extra;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic [N-1:0] d0, input logic [N-1:0] d1);
        req0  = r0;
        req1  = r1;
        data0 = d0;
        data1 = d1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("gnt_wait_expired", 32'(gnt0 | gnt1), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_wait_expired", 32'(busy), 0);
    endtask

    // One complete frame: request, grant, start, tx_done rise, then the gap.
    task automatic run_frame(input vec_t v);
        bit ok;
        int gap;
        wait_idle();
        applyStimulus(v.r0, v.r1, v.d0, v.d1);
        gnt_q.push_back('{v.exp_src, v.exp_data});
        done_q.push_back(v.exp_src);
        wait_gnt(ok);
        if (!ok) return;
        if (gnt1) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        checkOutput("start_tx_latency", 32'(start_tx), 1);
        checkOutput("gnt_one_cycle", 32'(gnt0 | gnt1), 0);
        checkOutput("data_held", 32'(data_out), 32'(v.exp_data));
        tick(3);
        tx_done = 1'b1;
        tick();
        checkOutput("done_pulse", 32'(done0 | done1), 1);
        tx_done = 1'b0;
        gap = 0;
        while (busy && gap < 40) begin
            gap++;
            @(negedge clk);
        end
        checkOutput("gap_busy_cycles", gap, 16);
    endtask

    always @(negedge clk) begin
        if (gnt0 || gnt1) begin
            checkOutput("gnt_exclusive", 32'(gnt0 & gnt1), 0);
            if (gnt_q.size() == 0) begin
                checkOutput("gnt_unexpected", 32'(gnt0 | gnt1), 0);
            end else begin
                mon_e = gnt_q.pop_front();
                checkOutput("gnt_src", 32'(gnt1), 32'(mon_e.src));
                checkOutput("gnt_data", 32'(data_out), 32'(mon_e.data));
                checkOutput("gnt_last_src", 32'(last_src), 32'(mon_e.src));
            end
        end
        if (done0 || done1) begin
            checkOutput("done_exclusive", 32'(done0 & done1), 0);
            if (done_q.size() == 0) begin
                checkOutput("done_unexpected", 32'(done0 | done1), 0);
            end else begin
                mon_d = done_q.pop_front();
                checkOutput("done_src", 32'(done1), 32'(mon_d));
            end
        end
        if (err && !expect_err) checkOutput("err_unexpected", 32'(err), 0);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        int cnt;

        vecs[0] = '{1'b1, 1'b1, 8'h55, 8'hCC, 1'b0, 8'h55};
        vecs[1] = '{1'b1, 1'b1, 8'h55, 8'hCC, 1'b1, 8'hCC};
        vecs[2] = '{1'b1, 1'b1, 8'h55, 8'hCC, 1'b0, 8'h55};
        vecs[3] = '{1'b1, 1'b0, 8'hAA, 8'h00, 1'b0, 8'hAA};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 8'h3C};
        vecs[5] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 8'h12};

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tx_done   = 1'b0;
        b_req0    = 1'b0;
        b_req1    = 1'b0;
        b_data0   = 8'h00;
        b_data1   = 8'h00;
        b_tx_done = 1'b0;

        #1 reset = 1'b0;
        #2;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_data_out", 32'(data_out), 0);
        checkOutput("reset_last_src", 32'(last_src), 1);
        checkOutput("reset_pulses", 32'({start_tx, gnt0, gnt1, done0, done1, err}), 0);

        // Both requesters already asserted while reset is held.
        applyStimulus(1'b1, 1'b1, 8'h55, 8'hCC);
        tick(2);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        // tx_done already high before WAIT must not complete the frame.
        wait_idle();
        tx_done = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h96);
        gnt_q.push_back('{1'b1, 8'h96});
        done_q.push_back(1'b1);
        wait_gnt(ok);
        req1 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0 || done1) cnt++;
        end
        checkOutput("stale_no_done", cnt, 0);
        checkOutput("stale_busy", 32'(busy), 1);
        tx_done = 1'b0;
        tick(2);
        checkOutput("stale_no_done_after_fall", 32'(done0 | done1), 0);
        tx_done = 1'b1;
        tick();
        checkOutput("stale_done_after_rise", 32'(done1), 1);
        tx_done = 1'b0;
        wait_idle();

        // Timeout: tx_done never rises.
        expect_err = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'hE7, 8'h00);
        gnt_q.push_back('{1'b0, 8'hE7});
        wait_gnt(ok);
        req0 = 1'b0;
        tick();
        checkOutput("timeout_start_tx", 32'(start_tx), 1);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        checkOutput("timeout_cycles", n, 100);
        checkOutput("timeout_idle", 32'(busy), 0);
        tick();
        checkOutput("err_one_cycle", 32'(err), 0);
        expect_err = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h5A);
        gnt_q.push_back('{1'b1, 8'h5A});
        wait_gnt(ok);
        req1 = 1'b0;
        tick(4);
        checkOutput("pre_reset_busy", 32'(busy), 1);
        #3 reset = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_data_out", 32'(data_out), 0);
        checkOutput("midreset_last_src", 32'(last_src), 1);
        checkOutput("midreset_pulses", 32'({start_tx, gnt0, gnt1, done0, done1, err}), 0);
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        checkOutput("post_reset_idle", 32'(busy), 0);
        extra = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h0F};
        run_frame(extra);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        // Zero gap: a held req1 is granted on the edge right after done1.
        b_req1  = 1'b1;
        b_data1 = 8'h3C;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_gnt1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("nogap_first_gnt1", 32'(b_gnt1), 1);
        checkOutput("nogap_gnt0_low", 32'(b_gnt0), 0);
        tick();
        checkOutput("nogap_start_tx", 32'(b_start_tx), 1);
        tick(2);
        b_tx_done = 1'b1;
        tick();
        checkOutput("nogap_done1", 32'(b_done1), 1);
        checkOutput("nogap_done0_low", 32'(b_done0), 0);
        checkOutput("nogap_idle_at_done", 32'(b_busy), 0);
        checkOutput("nogap_no_gnt_at_done", 32'(b_gnt1), 0);
        tick();
        checkOutput("nogap_second_gnt1", 32'(b_gnt1), 1);
        checkOutput("nogap_data_out", 32'(b_data_out), 32'(8'h3C));
        checkOutput("nogap_last_src", 32'(b_last_src), 1);
        b_req1    = 1'b0;
        b_tx_done = 1'b0;
        tick(3);
        b_tx_done = 1'b1;
        tick();
        checkOutput("nogap_second_done1", 32'(b_done1), 1);
        checkOutput("nogap_no_err", 32'(b_err), 0);
        b_tx_done = 1'b0;
        tick(2);

        checkOutput("gnt_queue_drained", gnt_q.size(), 0);
        checkOutput("done_queue_drained", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
